inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-cache interface: owns the PC and drives the cache's `ce`/`addr`.
- Captures the returned instruction words into a small in-order queue that feeds the decoder over a valid/ready handshake.
- Handles branch redirects and queue-full back-pressure; sits between the instruction cache and the decode/issue stage.

Parameters:
- ADDR_W, 32, PC / cache address width (equals `Inst_Addr_Width).
- INST_W, 32, instruction width (equals `Inst_Width).
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >=2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cache_ce  out  1  fetch request to instruction cache.
- cache_addr  out  ADDR_W  byte address of requested word (current PC).
- cache_inst  in  INST_W  instruction returned combinationally, same cycle as request.
- cache_enable  in  1  cache_inst valid this cycle.
- redirect_valid  in  1  branch/jump resolved taken; flush and refetch.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- dec_valid  out  1  queue head valid.
- dec_inst  out  INST_W  queue head instruction.
- dec_pc  out  ADDR_W  PC of queue head instruction.
- dec_ready  in  1  decoder accepts head this cycle.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, queue empty (rd_ptr=wr_ptr=count=0), state=IDLE. cache_ce=0, cache_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=0.
- FSM states:
  - IDLE: one cycle after reset; cache_ce=0; next state FETCH.
  - FETCH: cache_ce=1.
  - STALL: cache_ce=0.
- cache_ce and cache_addr are functions of registered state only (state, pc). There is no combinational path from dec_ready or redirect_valid to cache_ce or cache_addr.
- cache_addr = pc, with pc[1:0] always 0.
- Push: in FETCH with cache_enable=1, {cache_inst, pc} is written at wr_ptr and pc <= pc+4. Wrap-around is modulo 2^ADDR_W.
- FETCH with cache_enable=0: no push, pc holds, retry next cycle.
- Pop: dec_valid=1 and dec_ready=1 advances rd_ptr. dec_valid = (count!=0); dec_inst/dec_pc come from the rd_ptr entry. dec_inst and dec_pc read 0 when the queue is empty.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- Transitions (evaluated on next-cycle count):
  - FETCH -> STALL when count_next == QUEUE_DEPTH.
  - STALL -> FETCH when count_next < QUEUE_DEPTH.
  - A full queue never receives a push: STALL holds ce low even in the cycle a pop occurs, and fetch resumes the following cycle.
- Redirect (highest priority, any state except reset):
  - Queue flushed (pointers and count to 0); pc <= {redirect_pc[ADDR_W-1:2],2'b00}; state <= FETCH.
  - A push or pop in the same cycle is discarded.
  - dec_valid may be 1 in the redirect cycle. The decoder must also qualify the head with redirect_valid; the unit does not mask dec_valid combinationally.
- Reset asserted mid-operation: immediate return to reset values; queue contents are lost.
- Pointers are log2(QUEUE_DEPTH) bits; count is log2(QUEUE_DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_STAT_EN.
- Defined: adds outputs stat_fetched (32 bit, counts pushes) and stat_stall (32 bit, counts cycles in STALL, or in FETCH with cache_enable=0).
  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
  - Neither counter is cleared by redirect.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/defines file holds:
  - widths `Inst_Addr_Width and `Inst_Width;
  - FSM state encodings FETCH_IDLE=2'd0, FETCH_RUN=2'd1, FETCH_STALL=2'd2;
  - the constant PC_STEP=4.
- One sub-module: inst_queue, a synchronous FIFO holding {inst, pc} with push/pop/flush, full/empty and count.
- FSM and PC logic stay in inst_fetch_unit.

Test Plan:
- Reset release, cache always enabled, dec_ready=1 -> cycle 1 ce=0; then addrs 0x0,0x4,0x8...; dec_pc follows 1 cycle behind push; no gaps.
- dec_ready=0, QUEUE_DEPTH=4 -> exactly 4 pushes (pc 0x0..0xC), then ce=0 with pc=0x10. Raise dec_ready for 1 cycle -> pop of pc 0x0, ce=1 on the next cycle fetching 0x10.
- Queue holding 3 entries, redirect_valid=1 with redirect_pc=0x103 -> next cycle dec_valid=0, cache_addr=0x100; the following push has dec_pc=0x100.
- cache_enable=0 for 3 cycles during FETCH at pc=0x20 -> pc holds 0x20, no pushes, and the instruction at 0x20 is delivered once cache_enable returns.
- pc=0xFFFFFFFC, fetch -> next cache_addr=0x0 (wrap).
- rst pulled low mid-stream with queue at 2 -> immediately dec_valid=0, cache_ce=0, cache_addr=RESET_PC. With FETCH_STAT_EN defined, both counters read 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, fetch FSM encodings and PC step for the instruction fetch unit.
`ifndef INST_FETCH_UNIT_PKG_DEFS
`define INST_FETCH_UNIT_PKG_DEFS
`define Inst_Addr_Width 32
`define Inst_Width 32
`endif

package inst_fetch_unit_pkg;
  localparam int unsigned INST_ADDR_W = `Inst_Addr_Width;
  localparam int unsigned INST_DATA_W = `Inst_Width;

  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_RUN   = 2'd1;
  localparam logic [1:0] FETCH_STALL = 2'd2;

  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/inst_fetch_unit_queue.sv
// In-order instruction queue holding {inst, pc} pairs with push/pop/flush.
// Head outputs read zero while the queue is empty.
module inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [INST_W-1:0] head_inst,
  output logic [ADDR_W-1:0] head_pc
);
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        inst_mem_d[wr_ptr_q] = push_inst;
        pc_mem_d[wr_ptr_q]   = push_pc;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign head_inst = empty ? '0 : inst_mem_q[rd_ptr_q];
  assign head_pc   = empty ? '0 : pc_mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, requests the I-cache and queues words for decode.
// Optional FETCH_STAT_EN adds saturating fetch/stall statistics counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W      = INST_ADDR_W,
  parameter int unsigned       INST_W      = INST_DATA_W,
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cache_ce,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic [INST_W-1:0] cache_inst,
  input  logic              cache_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall
`endif
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(3);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push_c, pop_c;
  logic              q_full, q_empty;
  logic [CNT_W-1:0]  q_count, count_next_c;

  // Fetch outputs depend only on registered state and PC.
  assign cache_ce   = (state_q == FETCH_RUN);
  assign cache_addr = pc_q;

  assign push_c = (state_q == FETCH_RUN) && cache_enable && !q_full && !redirect_valid;
  assign pop_c  = !q_empty && dec_ready && !redirect_valid;

  inst_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_inst (cache_inst),
    .push_pc   (pc_q),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head_inst (dec_inst),
    .head_pc   (dec_pc)
  );

  assign dec_valid = !q_empty;

  always_comb begin
    count_next_c = q_count;
    if (push_c && !pop_c) begin
      count_next_c = q_count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_next_c = q_count - CNT_W'(1);
    end
  end

  // Redirect overrides every state; otherwise transitions look at next-cycle occupancy.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = FETCH_RUN;
      pc_d    = redirect_pc & PC_ALIGN_MASK;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_d = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (push_c) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
          end
          if (count_next_c == CNT_W'(QUEUE_DEPTH)) begin
            state_d = FETCH_STALL;
          end
        end
        FETCH_STALL: begin
          if (count_next_c < CNT_W'(QUEUE_DEPTH)) begin
            state_d = FETCH_RUN;
          end
        end
        default: begin
          state_d = FETCH_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC & PC_ALIGN_MASK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall_cycle_c;

  // Saturating counters; a redirect does not clear them.
  always_comb begin
    stall_cycle_c  = (state_q == FETCH_STALL) || ((state_q == FETCH_RUN) && !cache_enable);
    stat_fetched_d = stat_fetched_q;
    stat_stall_d   = stat_stall_q;
    if (push_c && (stat_fetched_q != 32'hFFFF_FFFF)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (stall_cycle_c && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stall   = stat_stall_q;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit; the cache returns addr ^ 0xC0DE0000.
module tb_inst_fetch_unit;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ce;
  logic [31:0] cache_addr;
  logic [31:0] cache_inst;
  logic        cache_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .ADDR_W      (32),
    .INST_W      (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cache_ce       (cache_ce),
    .cache_addr     (cache_addr),
    .cache_inst     (cache_inst),
    .cache_enable   (cache_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
`ifdef FETCH_STAT_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stall     (stat_stall)
`endif
  );

  assign cache_inst = cache_addr ^ TAG;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; cache_enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; cache_enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    step(); step();
    checks++; if (cache_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", cache_ce); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", cache_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dec_valid); end
    checks++; if (dec_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", dec_inst); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", dec_pc); end
    rst = 1'b1;
    #1;
    checks++; if (cache_ce !== 1'b0) begin errors++; $display("FAIL idle_ce got %b exp 0", cache_ce); end
    step();
    checks++; if (cache_ce !== 1'b1) begin errors++; $display("FAIL first_fetch_ce got %b exp 1", cache_ce); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL first_fetch_addr got %h exp 0", cache_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_addr = 32'(4 * k);
      exp_pc   = 32'(4 * (k - 1));
      checks++; if (cache_ce !== 1'b1) begin errors++; $display("FAIL stream_ce[%0d] got %b exp 1", k, cache_ce); end
      checks++; if (cache_addr !== exp_addr) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", k, cache_addr, exp_addr); end
      checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", k, dec_valid); end
      checks++; if (dec_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, dec_pc, exp_pc); end
      checks++; if (dec_inst !== (exp_pc ^ TAG)) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", k, dec_inst, exp_pc ^ TAG); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dec_ready = 1'b0;
    step(); step(); step();
    checks++; if (cache_ce !== 1'b1 || cache_addr !== 32'hC) begin errors++; $display("FAIL bp_third got ce=%b addr=%h exp ce=1 addr=c", cache_ce, cache_addr); end
    step();
    checks++; if (cache_ce !== 1'b0) begin errors++; $display("FAIL bp_full_ce got %b exp 0", cache_ce); end
    checks++; if (cache_addr !== 32'h10) begin errors++; $display("FAIL bp_full_addr got %h exp 10", cache_addr); end
    step();
    checks++; if (cache_ce !== 1'b0 || cache_addr !== 32'h10) begin errors++; $display("FAIL bp_hold got ce=%b addr=%h exp ce=0 addr=10", cache_ce, cache_addr); end
    checks++; if (dec_pc !== 32'h0 || dec_valid !== 1'b1) begin errors++; $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=0", dec_valid, dec_pc); end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    checks++; if (cache_ce !== 1'b1) begin errors++; $display("FAIL bp_resume_ce got %b exp 1", cache_ce); end
    checks++; if (cache_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_addr got %h exp 10", cache_addr); end
    checks++; if (dec_pc !== 32'h4) begin errors++; $display("FAIL bp_after_pop got %h exp 4", dec_pc); end
    step();
    checks++; if (cache_ce !== 1'b0 || cache_addr !== 32'h14) begin errors++; $display("FAIL bp_refill got ce=%b addr=%h exp ce=0 addr=14", cache_ce, cache_addr); end
`ifdef FETCH_STAT_EN
    checks++; if (stat_fetched !== 32'd5) begin errors++; $display("FAIL stat_fetched got %0d exp 5", stat_fetched); end
    checks++; if (stat_stall !== 32'd2) begin errors++; $display("FAIL stat_stall got %0d exp 2", stat_stall); end
`endif
  endtask

  task automatic test_redirect();
    do_reset();
    dec_ready = 1'b0;
    step(); step(); step();
    checks++; if (dec_valid !== 1'b1 || cache_addr !== 32'hC) begin errors++; $display("FAIL rd_pre got valid=%b addr=%h exp valid=1 addr=c", dec_valid, cache_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got %b exp 0", dec_valid); end
    checks++; if (cache_addr !== 32'h100) begin errors++; $display("FAIL rd_addr got %h exp 100", cache_addr); end
    checks++; if (cache_ce !== 1'b1) begin errors++; $display("FAIL rd_ce got %b exp 1", cache_ce); end
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin errors++; $display("FAIL rd_push got valid=%b pc=%h exp valid=1 pc=100", dec_valid, dec_pc); end
    checks++; if (dec_inst !== (32'h100 ^ TAG)) begin errors++; $display("FAIL rd_inst got %h exp %h", dec_inst, 32'h100 ^ TAG); end
  endtask

  task automatic test_cache_disable();
    do_reset();
    for (int k = 0; k < 8; k++) step();
    checks++; if (cache_addr !== 32'h20) begin errors++; $display("FAIL cd_start got %h exp 20", cache_addr); end
    cache_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (cache_ce !== 1'b1 || cache_addr !== 32'h20) begin errors++; $display("FAIL cd_hold[%0d] got ce=%b addr=%h exp ce=1 addr=20", k, cache_ce, cache_addr); end
    end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL cd_nopush got %b exp 0", dec_valid); end
    cache_enable = 1'b1;
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h20) begin errors++; $display("FAIL cd_deliver got valid=%b pc=%h exp valid=1 pc=20", dec_valid, dec_pc); end
    checks++; if (cache_addr !== 32'h24) begin errors++; $display("FAIL cd_advance got %h exp 24", cache_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (cache_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", cache_addr); end
    step();
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", cache_addr); end
    checks++; if (dec_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", dec_pc); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    dec_ready = 1'b0;
    step(); step();
    checks++; if (dec_valid !== 1'b1 || cache_addr !== 32'h8) begin errors++; $display("FAIL mr_pre got valid=%b addr=%h exp valid=1 addr=8", dec_valid, cache_addr); end
    rst = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", dec_valid); end
    checks++; if (cache_ce !== 1'b0) begin errors++; $display("FAIL mr_ce got %b exp 0", cache_ce); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL mr_addr got %h exp 0", cache_addr); end
    checks++; if (dec_pc !== 32'h0 || dec_inst !== 32'h0) begin errors++; $display("FAIL mr_head got pc=%h inst=%h exp 0 0", dec_pc, dec_inst); end
`ifdef FETCH_STAT_EN
    checks++; if (stat_fetched !== 32'd0 || stat_stall !== 32'd0) begin errors++; $display("FAIL mr_stats got %0d %0d exp 0 0", stat_fetched, stat_stall); end
`endif
    step();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_cache_disable();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
